// File: rtl/char_normalizer_if.sv
// Byte-stream bundle for char_normalizer: producer side, consumer side,
// flush control and the occupancy/drop status observed by the source.
interface char_normalizer_if;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] level;
  logic [7:0] dropped;

  // Environment side: feeds bytes, consumes output, observes status.
  modport master (
    output in_char, in_valid, flush, out_ready,
    input  in_ready, out_char, out_valid, level, dropped
  );

  // Normalizer side.
  modport slave (
    input  in_char, in_valid, flush, out_ready,
    output in_ready, out_char, out_valid, level, dropped
  );
endinterface

// File: rtl/char_normalizer.sv
// char_normalizer: lower-cases ASCII letters, turns TAB/LF/CR into spaces,
// collapses runs of spaces into one, and buffers the result in an 8-deep FIFO
// for the downstream block-keyword checker.
module char_normalizer #(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  char_normalizer_if.slave   bus
);

  localparam int DEPTH = 8;
  localparam logic [DATA_W-1:0] SPACE = 8'h20;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [2:0]        rd_ptr;
  logic [2:0]        wr_ptr;
  logic [3:0]        count;
  logic              last_space;
  logic [7:0]        drop_cnt;

  logic [DATA_W-1:0] norm_char;
  logic              push;
  logic              collapse;
  logic              store;
  logic              pop;

  // Whitespace becomes a plain space, upper case becomes lower case.
  function automatic logic [DATA_W-1:0] normalize(input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] r;
    r = c;
    if (c == 8'h09 || c == 8'h0A || c == 8'h0D)
      r = SPACE;
    else if (c >= 8'h41 && c <= 8'h5A)
      r = c + 8'h20;
    return r;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign bus.in_ready  = (count != 4'd8);
  assign bus.out_valid = (count != 4'd0);
  assign bus.out_char  = mem[rd_ptr];
  assign bus.level     = count;
  assign bus.dropped   = drop_cnt;

  assign norm_char = normalize(bus.in_char);
  assign push      = bus.in_valid && bus.in_ready;
  // A space following a stored space is accepted but never written.
  assign collapse  = push && (norm_char == SPACE) && last_space;
  assign store     = push && !collapse;
  assign pop       = bus.out_valid && bus.out_ready;

  // Control state: pointers, occupancy, space tracking and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= 3'd0;
      wr_ptr     <= 3'd0;
      count      <= 4'd0;
      last_space <= 1'b0;
      drop_cnt   <= 8'd0;
    end else if (bus.flush) begin
      rd_ptr     <= 3'd0;
      wr_ptr     <= 3'd0;
      count      <= 4'd0;
      last_space <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr     <= wr_ptr + 3'd1;
        last_space <= (norm_char == SPACE);
      end
      if (pop)
        rd_ptr <= rd_ptr + 3'd1;
      if (collapse)
        drop_cnt <= sat_inc(drop_cnt);
      case ({store, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (store && !bus.flush)
      mem[wr_ptr] <= norm_char;
  end

endmodule

// File: tb/tb_char_normalizer.sv
// Bench for char_normalizer: directed scenarios plus a randomized run, all
// checked every cycle against a queue-based model of the normalizer.
module tb_char_normalizer;

  logic clk;
  logic reset;
  char_normalizer_if bus();

  char_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned mq[$];
  bit           m_ls;
  int           m_drop;

  function automatic byte unsigned model_map(input byte unsigned c);
    if (c == 8'h09 || c == 8'h0A || c == 8'h0D) return 8'h20;
    if (c >= "A" && c <= "Z") return c + 8'h20;
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ls   = 1'b0;
      m_drop = 0;
    end else if (bus.flush) begin
      mq.delete();
      m_ls = 1'b0;
    end else begin
      bit do_pop, do_push;
      byte unsigned n;
      do_pop  = (mq.size() != 0) && bus.out_ready;
      do_push = bus.in_valid && (mq.size() < 8);
      n = model_map(bus.in_char);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (n == 8'h20 && m_ls) begin
          if (m_drop < 255) m_drop++;
        end else begin
          mq.push_back(n);
          m_ls = (n == 8'h20);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("out_valid", bus.out_valid, (mq.size() != 0));
    check("in_ready", bus.in_ready, (mq.size() < 8));
    check("level", bus.level, mq.size());
    check("dropped", bus.dropped, m_drop);
    if (mq.size() != 0) check("out_char", bus.out_char, mq[0]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input byte unsigned c);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    bus.out_ready = 1'b0;
  endtask

  byte unsigned src5 [5] = '{8'h42, 8'h65, 8'h47, 8'h69, 8'h4E};
  byte unsigned exp5 [5] = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E};
  int drop_before;

  initial begin
    reset         = 1'b1;
    bus.in_char   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_level", bus.level, 0);
    check("rst_dropped", bus.dropped, 0);
    reset = 1'b0;
    step();
    check("post_rst_level", bus.level, 0);

    // "BeGiN" held, then drained as "begin"
    for (int i = 0; i < 5; i++) push_byte(src5[i]);
    check("begin_level", bus.level, 5);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("begin_valid", bus.out_valid, 1);
      check("begin_char", bus.out_char, exp5[i]);
      step();
    end
    check("begin_empty", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // whitespace collapse
    push_byte(8'h20);
    push_byte(8'h09);
    push_byte(8'h0A);
    push_byte(8'h65);
    check("ws_level", bus.level, 2);
    check("ws_dropped", bus.dropped, 2);
    check("ws_head", bus.out_char, 8'h20);
    bus.out_ready = 1'b1;
    step();
    check("ws_second", bus.out_char, 8'h65);
    step();
    bus.out_ready = 1'b0;
    check("ws_drained", bus.level, 0);

    // full boundary
    for (int i = 0; i < 8; i++) push_byte(8'h61 + i);
    check("full_level", bus.level, 8);
    check("full_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h7A;
    step();
    check("ninth_refused", bus.level, 8);
    bus.out_ready = 1'b1;
    step();
    check("pop_at_full_level", bus.level, 7);
    check("pop_at_full_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("ninth_taken", bus.level, 8);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("ninth_last", bus.out_char, 8'h7A);
    step();
    bus.out_ready = 1'b0;
    check("full_drained", bus.level, 0);

    // simultaneous push/pop at level 3 across pointer wrap
    for (int i = 0; i < 3; i++) push_byte(8'h70 + i);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_char = 8'($urandom_range(8'h41, 8'h5A));
      step();
      check("pp_level", bus.level, 3);
    end
    bus.in_valid = 1'b0;
    drain();

    // flush with concurrent push, then space is stored again
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    push_byte(8'h20);
    check("fl_level_pre", bus.level, 4);
    drop_before = m_drop;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h41;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_level", bus.level, 0);
    check("fl_valid", bus.out_valid, 0);
    check("fl_dropped", bus.dropped, drop_before);
    push_byte(8'h20);
    check("fl_space_stored", bus.level, 1);
    drain();

    // asynchronous reset between edges
    for (int i = 0; i < 6; i++) push_byte(8'h30 + i);
    check("ar_level_pre", bus.level, 6);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_level", bus.level, 0);
    check("ar_dropped", bus.dropped, 0);
    step();
    reset = 1'b0;
    step();

    // randomized run, heavy on whitespace so dropped saturates
    for (int i = 0; i < 3000; i++) begin
      int pick;
      pick = $urandom_range(0, 9);
      case (pick)
        0, 1, 2: bus.in_char = 8'h20;
        3:       bus.in_char = 8'h09;
        4:       bus.in_char = 8'h0D;
        5:       bus.in_char = 8'h0A;
        default: bus.in_char = 8'($urandom_range(0, 255));
      endcase
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      bus.flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    check("sat_dropped", bus.dropped, 255);
    drain();
    check("final_level", bus.level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
